dmem_responder: RTL

- Multi-cycle data-memory responder.
- Serves load/store requests raised by the CPU control path (mem_read/mem_write plus the ALU address and rs2 data).
- Returns each load result after a fixed latency, using a valid/ready request and one-cycle response pulse.
- Sits between the MEM stage and the data-memory array; the pipeline stalls on is_busy.

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_array.sv | 27 ++
 rtl/dmem_responder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_LOAD    = 2'd0,
    OP_STORE   = 2'd1,
    OP_ILLEGAL = 2'd2
  } op_e;

  localparam int DEF_LATENCY   = 4;
  localparam int DEF_MEM_WORDS = 16384;

  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: synchronous write, combinational address, registered read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int WORDS  = DEF_MEM_WORDS,
  parameter int IDX_W  = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [WORDS];
  logic [DATA_W-1:0] rdata_q;

  // Read-before-write on a same-address collision; contents never reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
    rdata_q <= mem_q[idx_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: valid/ready request, fixed-latency one-cycle response.
// Optional DMEM_LAST_HIT_EN adds a one-entry last-access buffer giving 1-cycle load hits.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = DEF_MEM_WORDS,
  parameter int LATENCY   = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic              resp_valid,
  output logic [DATA_W-1:0] dout,
  output logic              err,
  output logic              is_busy,
  output state_e            dbg_state
);

  localparam int IDX_W = idx_width(MEM_WORDS);
  localparam int CNT_W = 4;

  // Handshake: a request transfers on a rising edge where req_valid, a qualifier
  // and req_ready are all high; the requester holds req_valid until then.
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  op_e                op_q, op_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  din_q, din_d;
  logic               err_q, err_d;
  logic               accept, hit, ram_we;
  logic [IDX_W-1:0]   req_idx;
  logic [DATA_W-1:0]  ram_rdata, resp_data;
  logic               unused_addr_bits;

  assign req_idx          = addr[IDX_W+1:2];
  assign unused_addr_bits = ^addr[ADDR_W-1:IDX_W+2];
  assign accept           = req_valid & (mem_read | mem_write) & (state_q != BUSY);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    idx_d   = idx_q;
    din_d   = din_q;
    err_d   = err_q;
    unique case (state_q)
      BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: ;
    endcase
    if (accept) begin
      state_d = hit ? RESP : BUSY;
      cnt_d   = hit ? '0 : CNT_W'(LATENCY - 1);
      op_d    = (mem_read & mem_write) ? OP_ILLEGAL : (mem_write ? OP_STORE : OP_LOAD);
      idx_d   = req_idx;
      din_d   = din;
      err_d   = (mem_read & mem_write) | (addr[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_LOAD;
      idx_q   <= '0;
      din_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      din_q   <= din_d;
      err_q   <= err_d;
    end
  end

  // Store commits on the edge that enters RESP; the load read lands on the same edge.
  assign ram_we = (state_q == BUSY) && (cnt_q == CNT_W'(1)) && (op_q == OP_STORE) && !err_q;

  dmem_array #(
    .WORDS  (MEM_WORDS),
    .IDX_W  (IDX_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .we_i    (ram_we),
    .idx_i   (idx_q),
    .wdata_i (din_q),
    .rdata_o (ram_rdata)
  );

`ifdef DMEM_LAST_HIT_EN
  logic              buf_valid_q, buf_valid_d;
  logic [IDX_W-1:0]  buf_idx_q, buf_idx_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic              hit_q;

  // The response completing this cycle is folded in so a back-to-back load sees it.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_idx_d   = buf_idx_q;
    buf_data_d  = buf_data_q;
    if (state_q == RESP && !err_q) begin
      buf_valid_d = 1'b1;
      buf_idx_d   = idx_q;
      buf_data_d  = (op_q == OP_STORE) ? din_q : resp_data;
    end
  end

  assign hit = mem_read & ~mem_write & (addr[1:0] == 2'b00) &
               buf_valid_d & (buf_idx_d == req_idx);
  assign resp_data = hit_q ? buf_data_q : ram_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_valid_q <= 1'b0;
      buf_idx_q   <= '0;
      buf_data_q  <= '0;
      hit_q       <= 1'b0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_idx_q   <= buf_idx_d;
      buf_data_q  <= buf_data_d;
      if (accept) hit_q <= hit;
    end
  end
`else
  assign hit       = 1'b0;
  assign resp_data = ram_rdata;
`endif

  assign req_ready  = (state_q != BUSY);
  assign is_busy    = (state_q == BUSY);
  assign resp_valid = (state_q == RESP);
  assign err        = (state_q == RESP) & err_q;
  assign dout       = ((state_q == RESP) && (op_q == OP_LOAD) && !err_q) ? resp_data : '0;
  assign dbg_state  = state_q;

endmodule
